// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the 16-bit multicycle CPU: opcodes, ALU ops, mux selects,
// FSM state encoding and the packed control word driven by multicycle_ctrl.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_ADDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_BEQZ = 4'h8,
    OP_JMP  = 4'h9,
    OP_LI   = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_PC   = 2'b00,
    SRCA_A    = 2'b01,
    SRCA_ZERO = 2'b10
  } srca_t;

  typedef enum logic [1:0] {
    SRCB_B   = 2'b00,
    SRCB_ONE = 2'b01,
    SRCB_IMM = 2'b10
  } srcb_t;

  typedef enum logic [1:0] {
    PCSEL_ALU = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_JMP = 2'b10
  } pcsel_t;

  typedef enum logic {
    ADDR_PC  = 1'b0,
    ADDR_ALU = 1'b1
  } addr_sel_t;

  typedef enum logic [3:0] {
    S_IF1  = 4'd0,
    S_IF2  = 4'd1,
    S_ID   = 4'd2,
    S_BR   = 4'd3,
    S_EXR  = 4'd4,
    S_EXI  = 4'd5,
    S_WB   = 4'd6,
    S_MA   = 4'd7,
    S_LDR  = 4'd8,
    S_LDM  = 4'd9,
    S_LDW  = 4'd10,
    S_STW  = 4'd11,
    S_HALT = 4'd12
  } state_t;

  typedef struct packed {
    logic      IRload;
    logic      Aload;
    logic      Bload;
    logic      ALUOutLoad;
    logic      MDRload;
    logic      RegWrite;
    logic      MemRead;
    logic      MemWrite;
    logic      MemToReg;
    addr_sel_t AddrSel;
    logic      PCWrite;
    srca_t     ALUSrcA;
    srcb_t     ALUSrcB;
    alu_op_t   ALUOp;
    pcsel_t    PCSel;
    logic      halted;
    logic      illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode and zero flag in, every enable and select out.
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite;
  logic       MemRead, MemWrite, MemToReg, AddrSel, PCWrite;
  logic [1:0] ALUSrcA, ALUSrcB, PCSel;
  logic [2:0] ALUOp;

  modport master (
    input  opcode, zero,
    output IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
           MemRead, MemWrite, MemToReg, AddrSel, PCWrite,
           ALUSrcA, ALUSrcB, PCSel, ALUOp
  );

  modport slave (
    output opcode, zero,
    input  IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
           MemRead, MemWrite, MemToReg, AddrSel, PCWrite,
           ALUSrcA, ALUSrcB, PCSel, ALUOp
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; exactly one class flag is high for any opcode.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_imm,
  output logic       is_ld,
  output logic       is_st,
  output logic       is_br,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_alu     = 1'b0;
    is_imm     = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_br      = 1'b0;
    is_jmp     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    // The halt opcode is a parameter, so it takes priority over the fixed table.
    if (opcode == HALT_OPCODE) begin
      is_halt = 1'b1;
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu = 1'b1;
        OP_ADDI, OP_LI:                        is_imm = 1'b1;
        OP_LD:                                 is_ld  = 1'b1;
        OP_ST:                                 is_st  = 1'b1;
        OP_BEQZ:                               is_br  = 1'b1;
        OP_JMP:                                is_jmp = 1'b1;
        default:                               is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath: fetch/decode/execute/memory/writeback,
// with run gating in IF1, halt parking, illegal-opcode pulse and a retired-instruction count.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int         CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  multicycle_ctrl_if.master   dp,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_t state_q, state_d;
  logic   retire;
  ctrl_t  c;
  logic   is_alu, is_imm, is_ld, is_st, is_br, is_jmp, is_halt, is_illegal;

  ctrl_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
    .opcode     (dp.opcode),
    .is_alu     (is_alu),
    .is_imm     (is_imm),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_br      (is_br),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF1;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IF1: if (run) state_d = S_IF2;
      S_IF2: state_d = S_ID;
      S_ID: begin
        if (is_jmp) begin
          state_d = S_IF1;
          retire  = 1'b1;
        end else if (is_br) begin
          if (dp.zero) begin
            state_d = S_BR;
          end else begin
            state_d = S_IF1;
            retire  = 1'b1;
          end
        end else if (is_halt) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (is_alu) begin
          state_d = S_EXR;
        end else if (is_imm) begin
          state_d = S_EXI;
        end else if (is_ld || is_st) begin
          state_d = S_MA;
        end else begin
          state_d = S_IF1;
        end
      end
      S_BR: begin
        state_d = S_IF1;
        retire  = 1'b1;
      end
      S_EXR, S_EXI: state_d = S_WB;
      S_MA: begin
        if (is_ld)      state_d = S_LDR;
        else if (is_st) state_d = S_STW;
        else            state_d = S_IF1;
      end
      S_LDR: state_d = S_LDM;
      S_LDM: state_d = S_LDW;
      S_WB, S_LDW, S_STW: begin
        state_d = S_IF1;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF1;
    endcase
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_IF1: begin
        if (run) begin
          c.AddrSel    = ADDR_PC;
          c.MemRead    = 1'b1;
          c.ALUSrcA    = SRCA_PC;
          c.ALUSrcB    = SRCB_ONE;
          c.ALUOp      = ALU_ADD;
          c.ALUOutLoad = 1'b1;
        end
      end
      S_IF2: begin
        c.IRload  = 1'b1;
        c.PCWrite = 1'b1;
        c.PCSel   = PCSEL_ALU;
      end
      S_ID: begin
        // Branch target PC+1+imm is precomputed here for every opcode.
        c.Aload      = 1'b1;
        c.Bload      = 1'b1;
        c.ALUSrcA    = SRCA_PC;
        c.ALUSrcB    = SRCB_IMM;
        c.ALUOp      = ALU_ADD;
        c.ALUOutLoad = 1'b1;
        c.illegal    = is_illegal;
        if (is_jmp) begin
          c.PCWrite = 1'b1;
          c.PCSel   = PCSEL_JMP;
        end
      end
      S_BR: begin
        c.PCWrite = 1'b1;
        c.PCSel   = PCSEL_BR;
      end
      S_EXR: begin
        c.ALUSrcA    = SRCA_A;
        c.ALUSrcB    = SRCB_B;
        c.ALUOp      = alu_op_t'(dp.opcode[2:0]);
        c.ALUOutLoad = 1'b1;
      end
      S_EXI: begin
        c.ALUSrcA    = (dp.opcode == OP_ADDI) ? SRCA_A : SRCA_ZERO;
        c.ALUSrcB    = SRCB_IMM;
        c.ALUOp      = ALU_ADD;
        c.ALUOutLoad = 1'b1;
      end
      S_WB: c.RegWrite = 1'b1;
      S_MA: begin
        c.ALUSrcA    = SRCA_ZERO;
        c.ALUSrcB    = SRCB_IMM;
        c.ALUOp      = ALU_ADD;
        c.ALUOutLoad = 1'b1;
      end
      S_LDR: begin
        c.AddrSel = ADDR_ALU;
        c.MemRead = 1'b1;
      end
      S_LDM: c.MDRload = 1'b1;
      S_LDW: begin
        c.RegWrite = 1'b1;
        c.MemToReg = 1'b1;
      end
      S_STW: begin
        c.AddrSel  = ADDR_ALU;
        c.MemWrite = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    // Outputs are forced quiet for the whole reset window, even with run high in IF1.
    if (reset) c = '0;
  end

  assign dp.IRload     = c.IRload;
  assign dp.Aload      = c.Aload;
  assign dp.Bload      = c.Bload;
  assign dp.ALUOutLoad = c.ALUOutLoad;
  assign dp.MDRload    = c.MDRload;
  assign dp.RegWrite   = c.RegWrite;
  assign dp.MemRead    = c.MemRead;
  assign dp.MemWrite   = c.MemWrite;
  assign dp.MemToReg   = c.MemToReg;
  assign dp.AddrSel    = c.AddrSel;
  assign dp.PCWrite    = c.PCWrite;
  assign dp.ALUSrcA    = c.ALUSrcA;
  assign dp.ALUSrcB    = c.ALUSrcB;
  assign dp.ALUOp      = c.ALUOp;
  assign dp.PCSel      = c.PCSel;
  assign halted        = c.halted;
  assign illegal       = c.illegal;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM control unit that sequences the 16-bit multicycle Von Neumann datapath through fetch, decode, execute, memory and writeback.
- Consumes opcode/zero feedback from the datapath.
- Drives every latch enable, mux select, ALU op and memory strobe.
- Provides run gating, halt detection, an illegal-opcode flag and a retired-instruction counter for the testbench and top level.

Parameters:
HALT_OPCODE, 4'hF, opcode that parks the FSM in HALT
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
run  in  1  fetch enable; sampled only in IF1
opcode  in  4  IR[15:12] from datapath
zero  in  1  BEQZ condition (regfile data1 == 0), valid in ID
IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite  out  1 each  latch/register enables
MemRead, MemWrite, MemToReg, AddrSel, PCWrite  out  1 each  memory strobes, writeback select, address select, PC write
ALUSrcA  out  2  00 PC, 01 A, 10 zero
ALUSrcB  out  2  00 B, 01 +1, 10 imm16
ALUOp  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASSB
PCSel  out  2  00 ALUOut, 01 branch ALUOut, 10 jump immediate
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on an undefined opcode in ID
retired  out  CNT_W  count of completed instructions

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (rd=rs op rt); 5 ADDI (rd=rs+imm); 6 LD (rd=M[imm]); 7 ST (M[imm]=rd); 8 BEQZ (if rd==0, PC=PC+1+imm); 9 JMP (PC=IR[11:0]); A LI (rd=imm); HALT_OPCODE halt; all others illegal.
- Memory: one-cycle read latency. readData is valid in the cycle after the MemRead cycle.
- Outputs are decoded from the state register, plus opcode/zero in ID. Every output not listed for a state is 0.
- While reset is high: state=IF1, retired=0, and every output is 0, including MemRead.
- States and asserted outputs:
  - IF1: if run=0, assert nothing and stay in IF1. Otherwise assert AddrSel=0, MemRead, ALUSrcA=00, ALUSrcB=01, ADD, ALUOutLoad; next state IF2.
  - IF2: assert IRload, PCWrite, PCSel=00; next state ID.
  - ID: assert Aload, Bload, ALUSrcA=00, ALUSrcB=10, ADD, ALUOutLoad (branch target).
    - JMP: also assert PCWrite, PCSel=10; next IF1; retire.
    - BEQZ: zero=1 goes to BR; zero=0 goes to IF1 and retires.
    - HALT_OPCODE: go to HALT and retire.
    - Illegal: pulse illegal, go to IF1, do not retire.
    - ALU ops to EXR; ADDI/LI to EXI; LD/ST to MA.
  - BR: assert PCWrite, PCSel=01; next IF1; retire.
  - EXR: assert ALUSrcA=01, ALUSrcB=00, ALUOp=opcode[2:0], ALUOutLoad; next WB.
  - EXI: assert ALUSrcA=01 (ADDI) or 10 (LI), ALUSrcB=10, ADD, ALUOutLoad; next WB.
  - WB: assert RegWrite, MemToReg=0; next IF1; retire.
  - MA: assert ALUSrcA=10, ALUSrcB=10, ADD, ALUOutLoad. LD goes to LDR; ST goes to STW.
  - LDR: assert AddrSel=1, MemRead; next LDM.
  - LDM: assert MDRload; next LDW.
  - LDW: assert RegWrite, MemToReg=1; next IF1; retire.
  - STW: assert AddrSel=1, MemWrite; next IF1; retire.
  - HALT: halted=1; stay until reset.
- Cycle counts per instruction, including fetch: ALU/ADDI/LI 5; LD 7; ST 5; JMP 3; BEQZ 4 taken / 3 not taken.
- Retire means retired increments on the clock edge that leaves the final state. The counter wraps modulo 2^CNT_W.
- Invariants:
  - MemRead and MemWrite are never both high.
  - PCWrite is high only in IF2, BR, or ID with JMP.
  - RegWrite is high only in WB or LDW.
- run is ignored outside IF1: an in-flight instruction always completes.
- Reset asserted mid-instruction returns the FSM to IF1 immediately. No partial write occurs after reset assertion.

Decomposition:
- Shared include cpu_defs.vh holds:
  - opcode constants;
  - ALUOp codes;
  - ALUSrcA, ALUSrcB, PCSel and AddrSel encodings;
  - state encoding localparams (4-bit binary).
- The datapath also includes cpu_defs.vh.
- One sub-module, ctrl_decode: a combinational opcode classifier. It outputs is_alu, is_imm, is_ld, is_st, is_br, is_jmp, is_halt, is_illegal.

Test Plan:
1. Reset, then run=1 with program LI r1,5; ADDI r2,r1,3; ST r2,0x20; HALT → M[0x20]=8, halted=1 after 5+5+5+3 cycles, retired=4.
2. LD r3,0x20 with M[0x20]=16'hBEEF → MemRead with AddrSel=1 in cycle 4, MDRload in cycle 5, RegWrite with MemToReg=1 in cycle 6; r3=BEEF.
3. BEQZ r0,+2 with r0=0 at PC=0 → PC=3 after 4 cycles. Repeat with r0=1 → PC=1 after 3 cycles.
4. JMP 0x123 → PCSel=10 in ID; PC=0x123; retired+1.
5. Opcode 4'hB → illegal pulses for exactly one cycle, retired unchanged, next fetch from PC+1. Hold run=0 in IF1 for 10 cycles → no MemRead, PC constant.
6. Assert reset in LDR (LD in flight) → all outputs 0 at once; no RegWrite follows; FSM refetches from PC=0.
